fft_frame_gen: RTL and testbench
================================

// Module: fft_frame_gen
// PURPOSE
//  Parametrised framed stimulus source for the fft_N pipeline family; successor to data_gen.
//  Emits frames of N=2^LAYER complex samples, with start on the first sample and over on the last.
//  Adds selectable waveform modes, a programmable inter-frame gap, a frame-count limit with done, and enable/stop control.
//  Sits in benches and BIST paths directly ahead of fft_16/fft_8 style cores (start/end16, A_real/A_img).
// PARAMETERS
//  LAYER      4       log2 frame length; legal 1..10; N=2^LAYER
//  DATA_W     32      width of data_real/data_img (>=16)
//  GAP        2       idle cycles between frames; 0 = back-to-back frames
//  NUM_FRAMES 0       frames per run; 0 = continuous until en drops
//  AMP        256     amplitude for impulse/constant modes
//  SEED       16'hACE1 LFSR reset/restart value (must be non-zero)
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous reset, active-high
//  en         in   1       run request; level-sensitive
//  mode       in   2       0 ramp, 1 impulse, 2 constant, 3 LFSR noise
//  data_real  out  DATA_W  sample real part (two's complement)
//  data_img   out  DATA_W  sample imaginary part
//  valid      out  1       sample valid
//  start      out  1       first sample of frame (idx 0), coincident with valid
//  over       out  1       last sample of frame (idx N-1), coincident with valid
//  busy       out  1       state != IDLE
//  done       out  1       NUM_FRAMES completed; held until en low
//  frame_cnt  out  16      frames completed this run; saturates at 16'hFFFF
// BEHAVIOUR
//  - All outputs are registered. Reset (async, any time, incl. mid-frame): every output is 0, state IDLE, idx 0, lfsr=SEED, frame_cnt 0.
//  - FSM: IDLE -> RUN when en=1. RUN -> GAP after idx N-1 (or -> RUN if GAP=0).
//    GAP -> RUN after GAP cycles. End of frame with frame_cnt+1==NUM_FRAMES -> DONE.
//    End of frame with en=0 -> IDLE. DONE -> IDLE when en=0.
//  - Latency: en seen high in IDLE at edge t -> valid=start=1 with idx 0 visible after edge t+1.
//  - valid=1 for exactly N consecutive cycles per frame; 0 in IDLE/GAP/DONE; data_* = 0 when valid=0.
//  - en deasserted mid-frame: the frame completes untruncated, then IDLE (no GAP). en re-asserted during GAP: ignored (gap runs out).
//  - mode is sampled at idx 0 and held for the whole frame; a change mid-frame takes effect next frame.
//  - ramp: real=idx zero-extended, img=0.
//    impulse: real=AMP at idx 0, else 0; img=0.
//    constant: real=AMP, img=0.
//    LFSR: 16-bit Fibonacci x^16+x^14+x^13+x^11+1, one step per valid cycle; real=sext(lfsr), img=sext(bit-reversed lfsr).
//    State persists across frames; reset to SEED only by rst or IDLE->RUN.
//  - frame_cnt increments on the cycle after over; cleared on IDLE->RUN. done rises on the same cycle state enters DONE.
//  - LAYER=1: start and over in consecutive cycles. N=1 is not supported.
//  - Simultaneous over and en falling: the frame is counted, then IDLE. NUM_FRAMES reached takes priority over en=0 (go DONE).
// STRUCTURE
//  - Shared package fft_pkg: mode encodings (MODE_RAMP..MODE_LFSR) and FSM state encodings (IDLE/RUN/GAP/DONE), reused by future fft_N cores and checkers.
//  - One sub-module: lfsr_16 (clk, rst, load, seed, step, q), reused by the noise mode and scoreboard models.
//  - Top holds the FSM, idx counter (LAYER bits), gap counter ($clog2(GAP+1)), frame counter, and output registers.
// TESTING
//  1) LAYER=4, GAP=2, mode 0, en held: start at idx 0, over at idx 15, real 0..15, 2 idle cycles, next start; frame_cnt steps 1,2,3.
//  2) NUM_FRAMES=3, mode 2, AMP=256: 3 frames of real=256, then done=1, busy=1, valid=0; drop en -> IDLE, done=0 next cycle.
//  3) mode 1 into fft_16: impulse real=256 at idx 0 only; fft output is flat, 256 in every bin, img 0.
//  4) rst pulsed at idx 7 of a frame: all outputs 0 immediately; en held -> fresh frame with start, idx 0, frame_cnt 0.
//  5) en dropped at idx 5: frame runs to over at idx 15, then IDLE; GAP=0 config gives back-to-back start after over with no idle cycle.
//  6) mode 3, SEED=16'hACE1: first 4 real samples match the bench lfsr_16 model; mode switched to 0 mid-frame takes effect only at the next start.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared encodings for the fft_N family: waveform modes, frame-generator FSM states, helpers.
package fft_pkg;

  localparam logic [1:0] MODE_RAMP    = 2'd0;
  localparam logic [1:0] MODE_IMPULSE = 2'd1;
  localparam logic [1:0] MODE_CONST   = 2'd2;
  localparam logic [1:0] MODE_LFSR    = 2'd3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StGap  = 2'd2,
    StDone = 2'd3
  } fsm_state_e;

  function automatic logic [15:0] bit_rev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) begin
      r[i] = v[15-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/lfsr_16.sv
// 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifting right with feedback into bit 15.
module lfsr_16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] q
);

  logic fb;

  assign fb = q[0] ^ q[2] ^ q[3] ^ q[5];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= SEED;
    end else if (load) begin
      q <= seed;
    end else if (step) begin
      q <= {fb, q[15:1]};
    end
  end

endmodule

// File: rtl/fft_frame_gen.sv
// Framed complex stimulus source: N=2^LAYER samples per frame with start/over markers,
// selectable waveform, inter-frame gap, optional frame limit with done.
module fft_frame_gen
  import fft_pkg::*;
#(
  parameter int unsigned LAYER      = 4,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned GAP        = 2,
  parameter int unsigned NUM_FRAMES = 0,
  parameter int unsigned AMP        = 256,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] data_real,
  output logic [DATA_W-1:0] data_img,
  output logic              valid,
  output logic              start,
  output logic              over,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frame_cnt
);

  localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  fsm_state_e         state;
  logic [LAYER-1:0]   idx;
  logic [GW-1:0]      gap_cnt;
  logic [1:0]         frame_mode;
  logic [1:0]         cur_mode;
  logic [DATA_W-1:0]  smp_real;
  logic [DATA_W-1:0]  smp_img;
  logic [15:0]        lfsr_q;
  logic [15:0]        lfsr_rev;
  logic               last;
  logic               frame_hit;
  logic               lfsr_load;
  logic               lfsr_step;

  assign last      = &idx;
  assign frame_hit = (NUM_FRAMES != 0) && ((32'(frame_cnt) + 32'd1) == NUM_FRAMES);
  assign lfsr_load = (state == StIdle) && en;
  assign lfsr_step = (state == StRun);
  assign lfsr_rev  = bit_rev16(lfsr_q);

  lfsr_16 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .seed (SEED),
    .step (lfsr_step),
    .q    (lfsr_q)
  );

  // The mode input is only honoured on idx 0; the rest of the frame uses the latched copy.
  always_comb begin
    cur_mode = (idx == '0) ? mode : frame_mode;
    smp_real = '0;
    smp_img  = '0;
    case (cur_mode)
      MODE_RAMP:    smp_real = DATA_W'(idx);
      MODE_IMPULSE: if (idx == '0) smp_real = DATA_W'(AMP);
      MODE_CONST:   smp_real = DATA_W'(AMP);
      MODE_LFSR: begin
        smp_real = DATA_W'($signed(lfsr_q));
        smp_img  = DATA_W'($signed(lfsr_rev));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      idx        <= '0;
      gap_cnt    <= '0;
      frame_mode <= MODE_RAMP;
      data_real  <= '0;
      data_img   <= '0;
      valid      <= 1'b0;
      start      <= 1'b0;
      over       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      valid     <= 1'b0;
      start     <= 1'b0;
      over      <= 1'b0;
      data_real <= '0;
      data_img  <= '0;
      // A frame is counted the cycle after its over; a fresh run's clear below overrides this.
      if (over && (frame_cnt != 16'hFFFF)) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      case (state)
        StIdle: begin
          if (en) begin
            state     <= StRun;
            busy      <= 1'b1;
            idx       <= '0;
            frame_cnt <= '0;
          end
        end
        StRun: begin
          valid      <= 1'b1;
          start      <= (idx == '0);
          over       <= last;
          data_real  <= smp_real;
          data_img   <= smp_img;
          frame_mode <= cur_mode;
          idx        <= idx + 1'b1;
          if (last) begin
            if (frame_hit) begin
              state <= StDone;
              done  <= 1'b1;
            end else if (!en) begin
              state <= StIdle;
              busy  <= 1'b0;
            end else if (GAP == 0) begin
              state <= StRun;
            end else begin
              state   <= StGap;
              gap_cnt <= GW'(GAP - 1);
            end
          end
        end
        StGap: begin
          if (gap_cnt == '0) begin
            state <= StRun;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        StDone: begin
          if (!en) begin
            state <= StIdle;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_gen.sv
// Bench for fft_frame_gen: four configurations, directed vector table plus corner-case sequences.
module tb_fft_frame_gen;
  import fft_pkg::*;

  // {valid, start, over, busy, done, data_real, data_img, frame_cnt}
  typedef logic [84:0] st_t;

  typedef struct {
    logic       en;
    logic [1:0] mode;
    st_t        exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rstc;
  logic        en0, en1, en2, en3;
  logic [1:0]  mode0, mode1, mode2, mode3;
  logic [31:0] r0, i0, r1, i1, r2, i2, r3, i3;
  logic        v0, s0, o0, b0, d0;
  logic        v1, s1, o1, b1, d1;
  logic        v2, s2, o2, b2, d2;
  logic        v3, s3, o3, b3, d3;
  logic [15:0] fc0, fc1, fc2, fc3;
  st_t         st0, st1, st2, st3;

  assign st0 = {v0, s0, o0, b0, d0, r0, i0, fc0};
  assign st1 = {v1, s1, o1, b1, d1, r1, i1, fc1};
  assign st2 = {v2, s2, o2, b2, d2, r2, i2, fc2};
  assign st3 = {v3, s3, o3, b3, d3, r3, i3, fc3};

  fft_frame_gen #(.LAYER(4), .GAP(2), .NUM_FRAMES(0)) dut0 (
    .clk(clk), .rst(rst0), .en(en0), .mode(mode0), .data_real(r0), .data_img(i0),
    .valid(v0), .start(s0), .over(o0), .busy(b0), .done(d0), .frame_cnt(fc0)
  );

  fft_frame_gen #(.LAYER(4), .GAP(2), .NUM_FRAMES(3), .AMP(256)) dut1 (
    .clk(clk), .rst(rstc), .en(en1), .mode(mode1), .data_real(r1), .data_img(i1),
    .valid(v1), .start(s1), .over(o1), .busy(b1), .done(d1), .frame_cnt(fc1)
  );

  fft_frame_gen #(.LAYER(4), .GAP(0), .SEED(16'hACE1)) dut2 (
    .clk(clk), .rst(rstc), .en(en2), .mode(mode2), .data_real(r2), .data_img(i2),
    .valid(v2), .start(s2), .over(o2), .busy(b2), .done(d2), .frame_cnt(fc2)
  );

  fft_frame_gen #(.LAYER(1), .GAP(1)) dut3 (
    .clk(clk), .rst(rstc), .en(en3), .mode(mode3), .data_real(r3), .data_img(i3),
    .valid(v3), .start(s3), .over(o3), .busy(b3), .done(d3), .frame_cnt(fc3)
  );

  int n_tests;
  int n_fail;

  function automatic st_t mk(input logic v, input logic s, input logic o, input logic b,
                             input logic d, input logic [31:0] re, input logic [31:0] im,
                             input logic [15:0] fc);
    return {v, s, o, b, d, re, im, fc};
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  task automatic check(input string name, input st_t act, input st_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        vt [56];
    logic [15:0] lm;
    int          nv, nbad, novr, k;

    n_tests = 0;
    n_fail  = 0;
    rst0 = 1'b1; rstc = 1'b1;
    en0 = 1'b0; en1 = 1'b0; en2 = 1'b0; en3 = 1'b0;
    mode0 = MODE_RAMP; mode1 = MODE_CONST; mode2 = MODE_LFSR; mode3 = MODE_RAMP;

    // Ramp with en held for three frames; mode goes to impulse mid-frame 1, so frame 2 onward
    // must be impulse while frame 1 stays ramp.
    for (int c = 0; c < 56; c++) begin
      int   p, f;
      logic vv;
      p  = (c == 0) ? 16 : (c - 1) % 18;
      f  = (c == 0) ? 0 : (c - 1) / 18;
      vv = (p < 16);
      vt[c].en   = 1'b1;
      vt[c].mode = (c >= 24) ? MODE_IMPULSE : MODE_RAMP;
      vt[c].exp  = mk(vv, vv && (p == 0), vv && (p == 15), 1'b1, 1'b0,
                      !vv ? 32'd0 : (f >= 2) ? ((p == 0) ? 32'd256 : 32'd0) : 32'(p),
                      32'd0, (c >= 17) ? 16'((c - 17) / 18 + 1) : 16'd0);
    end

    tick;
    tick;
    check("reset_dut0", st0, '0);
    check("reset_dut1", st1, '0);
    rst0 = 1'b0;
    rstc = 1'b0;
    tick;
    check("idle_no_en", st0, '0);

    for (int c = 0; c < 56; c++) begin
      en0   = vt[c].en;
      mode0 = vt[c].mode;
      tick;
      check($sformatf("vec%0d", c), st0, vt[c].exp);
    end

    // Async reset at idx 7 of frame 3, then restart.
    mode0 = MODE_RAMP;
    repeat (7) tick;
    check("pre_rst_idx7", st0, mk(1, 0, 0, 1, 0, 0, 0, 3));
    #2 rst0 = 1'b1;
    #1;
    check("rst_async", st0, '0);
    #1 rst0 = 1'b0;
    tick;
    check("rst_rerun", st0, mk(0, 0, 0, 1, 0, 0, 0, 0));
    tick;
    check("rst_start", st0, mk(1, 1, 0, 1, 0, 0, 0, 0));

    // en dropped at idx 5: frame runs to completion, then idle without a gap.
    repeat (5) tick;
    check("idx5", st0, mk(1, 0, 0, 1, 0, 5, 0, 0));
    en0 = 1'b0;
    nv = 0;
    k  = 0;
    while (!o0 && k < 40) begin
      tick;
      k++;
      if (v0) nv++;
    end
    check("drop_en_over", st0, mk(1, 0, 1, 0, 0, 15, 0, 0));
    check("drop_en_len", st_t'(nv), st_t'(10));
    tick;
    check("drop_en_idle", st0, mk(0, 0, 0, 0, 0, 0, 0, 1));
    tick;
    check("stay_idle", st0, mk(0, 0, 0, 0, 0, 0, 0, 1));

    // Frame limit of 3 in constant mode.
    en1  = 1'b1;
    nv   = 0;
    nbad = 0;
    novr = 0;
    k    = 0;
    while (novr < 3 && k < 100) begin
      tick;
      k++;
      if (v1) begin
        nv++;
        if (r1 != 32'd256 || i1 != 32'd0) nbad++;
      end
      if (o1) novr++;
      if (d1 && novr < 3) nbad++;
    end
    check("nf_samples", st_t'(nv), st_t'(48));
    check("nf_bad", st_t'(nbad), '0);
    check("nf_done_at_over", st1, mk(1, 0, 1, 1, 1, 256, 0, 2));
    tick;
    check("nf_done", st1, mk(0, 0, 0, 1, 1, 0, 0, 3));
    repeat (3) tick;
    check("nf_hold", st1, mk(0, 0, 0, 1, 1, 0, 0, 3));
    en1 = 1'b0;
    tick;
    check("nf_release", st1, mk(0, 0, 0, 0, 0, 0, 0, 3));

    // LFSR mode from SEED, mode change mid-frame, back-to-back frames with GAP=0.
    en2 = 1'b1;
    tick;
    tick;
    check("lfsr0", st2, mk(1, 1, 0, 1, 0, 32'hFFFFACE1, 32'hFFFF8735, 0));
    tick;
    check("lfsr1", st_t'(r2), st_t'(32'h00005670));
    tick;
    check("lfsr2", st_t'(r2), st_t'(32'hFFFFAB38));
    tick;
    check("lfsr3", st_t'(r2), st_t'(32'h0000559C));
    mode2 = MODE_RAMP;
    repeat (7) tick;
    lm = 16'hACE1;
    repeat (10) lm = lfsr_next(lm);
    check("lfsr_mode_held", st_t'(r2), st_t'({{16{lm[15]}}, lm}));
    repeat (5) tick;
    check("gap0_over", st_t'({v2, o2}), st_t'(2'b11));
    tick;
    check("gap0_start", st2, mk(1, 1, 0, 1, 0, 0, 0, 1));
    tick;
    check("gap0_idx1", st2, mk(1, 0, 0, 1, 0, 1, 0, 1));
    en2 = 1'b0;

    // LAYER=1: start and over on consecutive cycles, one gap cycle.
    en3 = 1'b1;
    tick;
    tick;
    check("l1_start", st3, mk(1, 1, 0, 1, 0, 0, 0, 0));
    tick;
    check("l1_over", st3, mk(1, 0, 1, 1, 0, 1, 0, 0));
    tick;
    check("l1_gap", st3, mk(0, 0, 0, 1, 0, 0, 0, 1));
    tick;
    check("l1_restart", st3, mk(1, 1, 0, 1, 0, 0, 0, 1));
    en3 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
